// File: rtl/traffic_ctrl_nway_if.sv
// Signal bundle between the N-way traffic sequencer and its surroundings:
// timing/demand inputs in, lamp, phase and countdown outputs back.
interface traffic_ctrl_nway_if #(
    parameter int NUM_WAYS = 2,
    parameter int TIME_W   = 4
) ();
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    logic [NUM_WAYS*TIME_W-1:0] green_time;
    logic [NUM_WAYS-1:0]        demand;
    logic [3*NUM_WAYS-1:0]      lights;
    logic [WAY_W-1:0]           active_way;
    logic [1:0]                 phase;
    logic [TIME_W-1:0]          time_left;

    modport master (
        output green_time, demand,
        input  lights, active_way, phase, time_left
    );

    modport slave (
        input  green_time, demand,
        output lights, active_way, phase, time_left
    );
endinterface

// File: rtl/traffic_ctrl_nway.sv
// Round-robin, demand-actuated N-way traffic-light sequencer (GREEN -> YELLOW -> ALL_RED).
// All outputs decode purely from registered state.
module traffic_ctrl_nway #(
    parameter int NUM_WAYS     = 2,
    parameter int TIME_W       = 4,
    parameter int ALL_RED_SECS = 1
) (
    input  logic                 clk_1Hz,
    input  logic                 reset,
    traffic_ctrl_nway_if.slave   bus
);
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam logic [TIME_W-1:0] ONE      = TIME_W'(1);
    localparam logic [TIME_W-1:0] AR_LOAD  = TIME_W'(ALL_RED_SECS - 1);
    localparam logic [WAY_W-1:0]  LAST_WAY = WAY_W'(NUM_WAYS - 1);

    typedef enum logic [1:0] {
        PH_GREEN   = 2'b00,
        PH_YELLOW  = 2'b01,
        PH_ALL_RED = 2'b10
    } phase_e;

    phase_e              phase_q, phase_d;
    logic [TIME_W-1:0]   cnt_q, cnt_d;
    logic [TIME_W-1:0]   g_q, g_d;
    logic [WAY_W-1:0]    way_q, way_d;

    logic [WAY_W-1:0]    next_way;
    logic                found;
    logic [NUM_WAYS-1:0] served_mask;
    logic                other_demand;
    logic [TIME_W-1:0]   yellow_len;
    logic [TIME_W-1:0]   g_new;
    logic [3*NUM_WAYS-1:0] lights_s;

    function automatic logic [TIME_W-1:0] clamp_green(
        input logic [NUM_WAYS*TIME_W-1:0] gt,
        input logic [WAY_W-1:0]           w
    );
        logic [TIME_W-1:0] g;
        g = gt[int'(w)*TIME_W +: TIME_W];
        return (g == '0) ? ONE : g;
    endfunction

    // Search starts just after the last served way and ends on that way itself.
    always_comb begin
        next_way = (way_q == LAST_WAY) ? '0 : way_q + 1'b1;
        found    = 1'b0;
        for (int i = 1; i <= NUM_WAYS; i++) begin
            if (!found && bus.demand[(int'(way_q) + i) % NUM_WAYS]) begin
                found    = 1'b1;
                next_way = WAY_W'((int'(way_q) + i) % NUM_WAYS);
            end
        end
    end

    always_comb begin
        served_mask  = NUM_WAYS'(1) << way_q;
        other_demand = |(bus.demand & ~served_mask);
        yellow_len   = (g_q >> 1);
        if (yellow_len == '0) begin
            yellow_len = ONE;
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        way_d   = way_q;
        g_d     = g_q;
        g_new   = ONE;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end else begin
            case (phase_q)
                PH_ALL_RED: begin
                    g_new   = clamp_green(bus.green_time, next_way);
                    phase_d = PH_GREEN;
                    way_d   = next_way;
                    g_d     = g_new;
                    cnt_d   = g_new - ONE;
                end
                PH_GREEN: begin
                    if (other_demand) begin
                        phase_d = PH_YELLOW;
                        cnt_d   = yellow_len - ONE;
                    end else begin
                        // Nobody else waiting: hold green and take a fresh green time.
                        g_new = clamp_green(bus.green_time, way_q);
                        g_d   = g_new;
                        cnt_d = g_new - ONE;
                    end
                end
                PH_YELLOW: begin
                    phase_d = PH_ALL_RED;
                    cnt_d   = AR_LOAD;
                end
                default: begin
                    phase_d = PH_ALL_RED;
                    cnt_d   = AR_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk_1Hz or negedge reset) begin
        if (!reset) begin
            phase_q <= PH_ALL_RED;
            cnt_q   <= AR_LOAD;
            way_q   <= LAST_WAY;
            g_q     <= ONE;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            way_q   <= way_d;
            g_q     <= g_d;
        end
    end

    always_comb begin
        lights_s = {NUM_WAYS{3'b100}};
        if (phase_q == PH_GREEN) begin
            lights_s[int'(way_q)*3 +: 3] = 3'b001;
        end else if (phase_q == PH_YELLOW) begin
            lights_s[int'(way_q)*3 +: 3] = 3'b010;
        end
    end

    assign bus.lights     = lights_s;
    assign bus.active_way = way_q;
    assign bus.phase      = phase_q;
    assign bus.time_left  = cnt_q;

endmodule

// File: tb/tb_traffic_ctrl_nway.sv
// Scoreboard bench for traffic_ctrl_nway (4 ways): directed phase plans plus
// a randomised sweep checked against lamp/sequence invariants.
module tb_traffic_ctrl_nway;
    localparam int NW = 4;
    localparam int TW = 4;
    localparam logic [1:0] G  = 2'b00;
    localparam logic [1:0] Y  = 2'b01;
    localparam logic [1:0] AR = 2'b10;

    typedef struct {
        int         cyc;
        logic [1:0] ph;
        logic [1:0] way;
        logic [3:0] tl;
    } exp_t;

    logic clk_1Hz;
    logic reset;
    int   checks;
    int   errors;
    int   edge_cnt;
    int   plan_edge;
    exp_t sb_q[$];

    traffic_ctrl_nway_if #(.NUM_WAYS(NW), .TIME_W(TW)) bus ();

    traffic_ctrl_nway #(.NUM_WAYS(NW), .TIME_W(TW), .ALL_RED_SECS(1)) dut (
        .clk_1Hz (clk_1Hz),
        .reset   (reset),
        .bus     (bus.slave)
    );

    initial begin
        clk_1Hz = 1'b0;
        forever #5 clk_1Hz = ~clk_1Hz;
    end

    function automatic logic [11:0] exp_lights(input logic [1:0] ph, input logic [1:0] way);
        logic [11:0] l;
        l = 12'h924;
        if (ph == G) l[int'(way)*3 +: 3] = 3'b001;
        else if (ph == Y) l[int'(way)*3 +: 3] = 3'b010;
        return l;
    endfunction

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h at edge %0d", name, got, exp, edge_cnt);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic [NW-1:0] d, input logic [NW*TW-1:0] g);
        reset          = r;
        bus.demand     = d;
        bus.green_time = g;
    endtask

    task automatic push_one(input logic [1:0] ph, input logic [1:0] way, input logic [3:0] tl);
        exp_t e;
        plan_edge++;
        e.cyc = plan_edge;
        e.ph  = ph;
        e.way = way;
        e.tl  = tl;
        sb_q.push_back(e);
    endtask

    task automatic push_run(input logic [1:0] ph, input logic [1:0] way, input int len);
        for (int i = len - 1; i >= 0; i--) push_one(ph, way, 4'(i));
    endtask

    task automatic run_to_plan();
        int guard;
        guard = 0;
        while (edge_cnt < plan_edge && guard < 200) begin
            @(negedge clk_1Hz);
            guard++;
        end
        if (edge_cnt < plan_edge) check_output("plan_timeout", 32'(edge_cnt), 32'(plan_edge));
    endtask

    // Monitor: pops scheduled expectations and enforces lamp/sequence invariants every edge.
    logic [1:0] prev_ph;
    logic [1:0] prev_way;
    logic       prev_live;
    initial prev_live = 1'b0;

    always @(posedge clk_1Hz) begin
        exp_t e;
        int   non_red;
        logic onehot_ok;
        logic seq_ok;
        edge_cnt++;
        #1;
        while (sb_q.size() > 0 && sb_q[0].cyc <= edge_cnt) begin
            e = sb_q.pop_front();
            check_output($sformatf("sb_edge%0d", e.cyc),
                         {12'h0, bus.phase, bus.active_way, bus.time_left, bus.lights},
                         {12'h0, e.ph, e.way, e.tl, exp_lights(e.ph, e.way)});
        end
        onehot_ok = 1'b1;
        non_red   = 0;
        for (int k = 0; k < NW; k++) begin
            if (!$onehot(bus.lights[k*3 +: 3])) onehot_ok = 1'b0;
            if (bus.lights[k*3 +: 3] != 3'b100) non_red++;
        end
        check_output("inv_onehot", {31'h0, onehot_ok}, 32'h1);
        check_output("inv_non_red", 32'(non_red > 1), 32'h0);
        check_output("inv_phase11", {30'h0, bus.phase}, {30'h0, (bus.phase == 2'b11) ? 2'b00 : bus.phase});
        if (prev_live && reset) begin
            seq_ok = 1'b1;
            if (prev_ph == G && !((bus.phase == G || bus.phase == Y) && bus.active_way == prev_way)) seq_ok = 1'b0;
            if (prev_ph == Y && !((bus.phase == Y && bus.active_way == prev_way) || bus.phase == AR)) seq_ok = 1'b0;
            if (bus.phase == AR && prev_ph != AR && prev_ph != Y) seq_ok = 1'b0;
            check_output("inv_sequence", {31'h0, seq_ok}, 32'h1);
        end
        prev_ph   = bus.phase;
        prev_way  = bus.active_way;
        prev_live = reset;
    end

    initial begin
        checks    = 0;
        errors    = 0;
        edge_cnt  = 0;
        plan_edge = 0;
        apply_stimulus(1'b0, 4'b0011, 16'h4444);
        repeat (3) @(negedge clk_1Hz);

        // Two demanding ways, G=4: 7-edge phase per way, 14-edge cycle.
        reset     = 1'b1;
        plan_edge = edge_cnt;
        push_run(G, 2'd0, 4); push_run(Y, 2'd0, 2); push_run(AR, 2'd0, 1);
        push_run(G, 2'd1, 4); push_run(Y, 2'd1, 2); push_run(AR, 2'd1, 1);
        push_run(G, 2'd0, 4); push_one(Y, 2'd0, 4'd1);
        run_to_plan();

        // Asynchronous reset mid-yellow, between edges.
        #2 reset = 1'b0;
        #1 check_output("async_reset", {12'h0, bus.phase, bus.active_way, bus.time_left, bus.lights},
                        {12'h0, AR, 2'd3, 4'd0, 12'h924});
        @(negedge clk_1Hz);
        @(negedge clk_1Hz);

        // Skip: way1 and way3 idle.
        apply_stimulus(1'b1, 4'b0101, 16'h2222);
        plan_edge = edge_cnt;
        push_run(G, 2'd0, 2); push_run(Y, 2'd0, 1); push_run(AR, 2'd0, 1);
        push_run(G, 2'd2, 2); push_run(Y, 2'd2, 1); push_run(AR, 2'd2, 1);
        push_run(G, 2'd0, 2);
        run_to_plan();

        // Extension: only way0 wants service, green re-sampled at 3.
        apply_stimulus(1'b1, 4'b0001, 16'h2223);
        push_run(G, 2'd0, 3); push_one(G, 2'd0, 4'd2);
        run_to_plan();

        // Way1 arrives mid-green; new green times (way0=15, way1=0) only apply at next entry.
        apply_stimulus(1'b1, 4'b0011, 16'h220F);
        push_one(G, 2'd0, 4'd1); push_one(G, 2'd0, 4'd0);
        push_run(Y, 2'd0, 1); push_run(AR, 2'd0, 1);
        push_run(G, 2'd1, 1); push_run(Y, 2'd1, 1); push_run(AR, 2'd1, 1);
        push_run(G, 2'd0, 15); push_run(Y, 2'd0, 7); push_run(AR, 2'd0, 1);
        run_to_plan();

        // Random sweep: invariants only.
        for (int n = 0; n < 5000; n++) begin
            apply_stimulus(1'b1, 4'($urandom_range(0, 15)), 16'($urandom));
            @(negedge clk_1Hz);
        end
        check_output("sb_drain", 32'(sb_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
